// File: rtl/cgra_pkg.sv
// Shared CGRA definitions: datapath defaults and the vec_tx sequencing states.
package cgra_pkg;
    localparam int default_width      = 16;
    localparam int default_num_inputs = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } vec_tx_state_e;
endpackage

// File: rtl/vec_tx_if.sv
// Vector hand-off bus between the FU side and the neighbour-tile regfile write port.
interface vec_tx_if
    import cgra_pkg::*;
#(
    parameter int width      = default_width,
    parameter int num_inputs = default_num_inputs
);
    logic                                in_vld;
    logic [num_inputs-1:0][width-1:0]    in_data;
    logic                                in_rdy;
    logic                                wen;
    logic [num_inputs-1:0][width-1:0]    w_data;
    logic                                wr_ack;
    logic                                busy;
    logic                                err;

    modport slave (
        input  in_vld, in_data, wr_ack,
        output in_rdy, wen, w_data, busy, err
    );

    modport master (
        output in_vld, in_data, wr_ack,
        input  in_rdy, wen, w_data, busy, err
    );
endinterface

// File: rtl/vec_fifo.sv
// Vector FIFO with registered occupancy; head reads as zero while empty.
module vec_fifo #(
    parameter int width      = 16,
    parameter int num_inputs = 4,
    parameter int depth      = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push,
    input  logic [num_inputs-1:0][width-1:0]  push_data,
    input  logic                              pop,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(depth+1)-1:0]        count,
    output logic [num_inputs-1:0][width-1:0]  head
);
    localparam int ptr_w = (depth > 1) ? $clog2(depth) : 1;
    localparam int cnt_w = $clog2(depth + 1);

    logic [num_inputs-1:0][width-1:0] mem [depth];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == cnt_w'(depth));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // depth is a power of two, so pointers wrap naturally at their bit width
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ptr_w'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ptr_w'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/vec_tx.sv
// Sends buffered result vectors to a neighbour regfile, resending until acked or retries run out.
//   state | meaning
//   IDLE  | nothing in flight; retry count cleared
//   SEND  | one-cycle write strobe of the FIFO head
//   WAIT  | head held; pop on ack, resend, or drop after max_retries
module vec_tx
    import cgra_pkg::*;
#(
    parameter int width       = default_width,
    parameter int num_inputs  = default_num_inputs,
    parameter int fifo_depth  = 2,
    parameter int max_retries = 7
) (
    input  logic       clk,
    input  logic       reset,
    vec_tx_if.slave    bus
);
    localparam int retry_w = $clog2(max_retries + 1);
    localparam int cnt_w   = $clog2(fifo_depth + 1);
    localparam logic [retry_w-1:0] retry_max = retry_w'(max_retries);

    vec_tx_state_e      state, state_next;
    logic [retry_w-1:0] retry_q, retry_next;
    logic               err_q, set_err;
    logic               fifo_push, fifo_pop, fifo_full, fifo_empty, more_after_pop;
    logic [cnt_w-1:0]   fifo_count;
    logic [num_inputs-1:0][width-1:0] fifo_head;

    vec_fifo #(
        .width      (width),
        .num_inputs (num_inputs),
        .depth      (fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (bus.in_data),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign fifo_push      = bus.in_vld && !fifo_full;
    assign more_after_pop = (fifo_count > cnt_w'(1)) || fifo_push;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            retry_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_next;
            retry_q <= retry_next;
            if (set_err) err_q <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        retry_next = retry_q;
        fifo_pop   = 1'b0;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                retry_next = '0;
                if (!fifo_empty) state_next = SEND;
            end
            SEND: begin
                if (retry_q != retry_max) retry_next = retry_q + retry_w'(1);
                state_next = WAIT;
            end
            WAIT: begin
                if (bus.wr_ack || (retry_q == retry_max)) begin
                    fifo_pop   = 1'b1;
                    set_err    = !bus.wr_ack;
                    retry_next = '0;
                    state_next = more_after_pop ? SEND : IDLE;
                end else begin
                    state_next = SEND;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_rdy = !fifo_full;
    assign bus.wen    = (state == SEND);
    assign bus.w_data = fifo_head;
    assign bus.busy   = !fifo_empty || (state != IDLE);
    assign bus.err    = err_q;
endmodule

// File: tb/tb_vec_tx.sv
// Directed bench for vec_tx: latency, ordering, retries, drop, reset and stray acks.
module tb_vec_tx;
    import cgra_pkg::*;

    typedef logic [63:0] vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic man_ack = 1'b0;
    logic auto_ack = 1'b0;
    logic ack_pend = 1'b0;
    logic ack_en = 1'b0;
    int   ack_skip = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    vec_t wlog[$];

    vec_tx_if #(.width(16), .num_inputs(4)) bus ();

    vec_tx #(
        .width       (16),
        .num_inputs  (4),
        .fifo_depth  (2),
        .max_retries (7)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.wr_ack = man_ack | auto_ack;

    always #5 clk = ~clk;

    // Records every write strobe and answers it one cycle later unless told to skip.
    always @(posedge clk) begin
        #2;
        auto_ack = ack_pend;
        ack_pend = 1'b0;
        if (bus.wen === 1'b1) begin
            wlog.push_back(bus.w_data);
            if (ack_en) begin
                if (ack_skip > 0) ack_skip--;
                else ack_pend = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input vec_t v);
        bus.in_vld  = 1'b1;
        bus.in_data = v;
        for (int i = 0; i < 100; i++) begin
            if (bus.in_rdy) break;
            tick();
        end
        chk("push_rdy", 64'(bus.in_rdy), 64'd1);
        tick();
        bus.in_vld = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (!bus.busy) break;
            tick();
        end
        chk(tag, 64'(bus.busy), 64'd0);
    endtask

    function automatic vec_t log_at(input int idx);
        return (idx < wlog.size()) ? wlog[idx] : 'x;
    endfunction

    localparam vec_t v1 = {16'd1, 16'd2, 16'd3, 16'd4};
    localparam vec_t v2 = {16'h00aa, 16'h00bb, 16'h00cc, 16'h00dd};
    localparam vec_t v3 = {16'h1234, 16'h5678, 16'h9abc, 16'hdef0};
    localparam vec_t va = {16'h0a0a, 16'h0001, 16'h0002, 16'h0003};
    localparam vec_t vb = {16'h0b0b, 16'h0004, 16'h0005, 16'h0006};
    localparam vec_t vc = {16'h0c0c, 16'h0007, 16'h0008, 16'h0009};
    localparam vec_t d1 = {16'hd1d1, 16'hffff, 16'h0000, 16'h8001};
    localparam vec_t d2 = {16'hd2d2, 16'h7fff, 16'h0001, 16'h8002};
    localparam vec_t e1 = {16'he1e1, 16'h1111, 16'h2222, 16'h3333};
    localparam vec_t e2 = {16'he2e2, 16'h4444, 16'h5555, 16'h6666};
    localparam vec_t f1 = {16'hf1f1, 16'h0f0f, 16'hf0f0, 16'h0101};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        bus.in_vld  = 1'b0;
        bus.in_data = '0;
        #1;
        tick(); tick(); tick();
        reset = 1'b0;

        chk("rst_wen",    64'(bus.wen),    64'd0);
        chk("rst_wdata",  bus.w_data,      64'd0);
        chk("rst_in_rdy", 64'(bus.in_rdy), 64'd1);
        chk("rst_busy",   64'(bus.busy),   64'd0);
        chk("rst_err",    64'(bus.err),    64'd0);

        // single vector, manual ack in the cycle after the strobe
        wlog.delete();
        push(v1);
        chk("lat_n1_wen",   64'(bus.wen), 64'd0);
        tick();
        chk("lat_n2_wen",   64'(bus.wen), 64'd1);
        chk("lat_n2_wdata", bus.w_data,   v1);
        tick();
        chk("lat_n3_wen",   64'(bus.wen), 64'd0);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("lat_n4_busy",  64'(bus.busy), 64'd0);
        chk("lat_pulses",   64'(wlog.size()), 64'd1);

        // stray acks in IDLE and SEND leave the head in place
        wlog.delete();
        push(v2);
        man_ack = 1'b1;
        chk("stray_idle_busy", 64'(bus.busy), 64'd1);
        chk("stray_idle_wen",  64'(bus.wen),  64'd0);
        tick();
        chk("stray_send_wen",  64'(bus.wen),  64'd1);
        chk("stray_send_data", bus.w_data,    v2);
        tick();
        man_ack = 1'b0;
        chk("stray_wait_wen",  64'(bus.wen),  64'd0);
        chk("stray_wait_data", bus.w_data,    v2);
        chk("stray_wait_busy", 64'(bus.busy), 64'd1);
        tick();
        chk("stray_resend_wen",  64'(bus.wen), 64'd1);
        chk("stray_resend_data", bus.w_data,   v2);
        tick();
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("stray_done_busy", 64'(bus.busy), 64'd0);
        chk("stray_pulses",    64'(wlog.size()), 64'd2);
        chk("stray_err",       64'(bus.err), 64'd0);

        // three back-to-back pushes into a depth-2 FIFO
        wlog.delete();
        ack_en = 1'b1;
        ack_skip = 0;
        push(va);
        push(vb);
        chk("b2b_full_rdy", 64'(bus.in_rdy), 64'd0);
        push(vc);
        wait_idle("b2b_idle", 100);
        chk("b2b_count", 64'(wlog.size()), 64'd3);
        chk("b2b_first",  log_at(0), va);
        chk("b2b_second", log_at(1), vb);
        chk("b2b_third",  log_at(2), vc);

        // two unacked attempts, then acked
        wlog.delete();
        ack_skip = 2;
        push(v3);
        wait_idle("retry_idle", 100);
        chk("retry_count", 64'(wlog.size()), 64'd3);
        for (int i = 0; i < 3; i++) chk($sformatf("retry_data%0d", i), log_at(i), v3);
        chk("retry_err", 64'(bus.err), 64'd0);

        // never acked: dropped after seven attempts, next vector follows
        wlog.delete();
        ack_skip = 7;
        push(d1);
        push(d2);
        wait_idle("drop_idle", 200);
        chk("drop_count", 64'(wlog.size()), 64'd8);
        for (int i = 0; i < 7; i++) chk($sformatf("drop_data%0d", i), log_at(i), d1);
        chk("drop_next", log_at(7), d2);
        chk("drop_err",  64'(bus.err), 64'd1);
        tick(); tick(); tick();
        chk("drop_err_sticky", 64'(bus.err), 64'd1);

        // reset while waiting with two entries queued
        wlog.delete();
        ack_en = 1'b0;
        push(e1);
        push(e2);
        tick();
        chk("rstw_pre_busy", 64'(bus.busy), 64'd1);
        chk("rstw_pre_wen",  64'(bus.wen),  64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstw_wen",    64'(bus.wen),    64'd0);
        chk("rstw_busy",   64'(bus.busy),   64'd0);
        chk("rstw_in_rdy", 64'(bus.in_rdy), 64'd1);
        chk("rstw_err",    64'(bus.err),    64'd0);
        chk("rstw_wdata",  bus.w_data,      64'd0);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        tick();
        chk("rstw_late_busy",  64'(bus.busy), 64'd0);
        chk("rstw_late_wdata", bus.w_data,    64'd0);
        chk("rstw_late_wen",   64'(bus.wen),  64'd0);

        // block works normally afterwards
        wlog.delete();
        ack_en = 1'b1;
        ack_skip = 0;
        push(f1);
        wait_idle("post_idle", 100);
        chk("post_count", 64'(wlog.size()), 64'd1);
        chk("post_data",  log_at(0), f1);
        chk("post_err",   64'(bus.err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vec_tx.md
VEC_TX -- requirements
Module: vec_tx

Interface
REQ-001 Parameter width, default 16: bits per vector element.
REQ-002 Parameter num_inputs, default 4: elements per vector; matches one regfile write-port set.
REQ-003 Parameter fifo_depth, default 2: vector entries buffered; power of two, >= 2.
REQ-004 Parameter max_retries, default 7: unacknowledged send attempts allowed before the head vector is dropped; >= 1.
REQ-005 clk  input  1  single clock; all logic on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_vld  input  1  vector FU offers a result vector.
REQ-008 in_data  input  width x [num_inputs-1:0]  result vector elements.
REQ-009 in_rdy  output  1  vec_tx accepts in_data this cycle.
REQ-010 wen  output  1  write strobe to the neighbour tile regfile write port.
REQ-011 w_data  output  width x [num_inputs-1:0]  vector driven to the neighbour.
REQ-012 wr_ack  input  1  one-cycle write acknowledge from the neighbour regfile.
REQ-013 busy  output  1  FIFO non-empty or FSM not IDLE.
REQ-014 err  output  1  sticky; a vector was dropped after max_retries attempts.

Function
REQ-015 Input accept: a vector is pushed when in_vld && in_rdy; in_rdy = !full, from the registered occupancy count only; a pop in the same cycle does not raise in_rdy.
REQ-016 FIFO order: strict first-in first-out; wrap-around of read/write pointers at fifo_depth is seamless.
REQ-017 FSM states: IDLE, SEND, WAIT.
REQ-018 IDLE: wen = 0; go to SEND when FIFO non-empty; retry count cleared to 0.
REQ-019 SEND: wen = 1 for exactly one cycle; w_data = FIFO head; retry count +1; go to WAIT unconditionally.
REQ-020 WAIT: wen = 0; w_data holds the head.
REQ-021 WAIT with wr_ack = 1: pop head, clear retry count, go to SEND if another entry remains after the pop, else IDLE.
REQ-022 WAIT with wr_ack = 0 and retry count < max_retries: go to SEND and resend the same head.
REQ-023 WAIT with wr_ack = 0 and retry count = max_retries: pop and drop the head, set err, clear retry count, then go to SEND or IDLE per REQ-021.
REQ-024 wr_ack in IDLE or SEND is ignored; no pop, no state change.
REQ-025 Latency: a vector pushed in cycle N with an empty FIFO and IDLE FSM sees wen = 1 in cycle N+2 (IDLE->SEND in N+1); with the neighbour acking first try, throughput is one vector per 2 cycles.
REQ-026 w_data equals the FIFO head whenever wen = 1; it is 0 when the FIFO is empty.
REQ-027 The retry counter is ceil(log2(max_retries+1)) bits wide and never wraps.
REQ-028 err clears only on reset.

Reset
REQ-029 Reset takes priority over all other inputs, including in the middle of SEND or WAIT.
REQ-030 On the cycle after reset is sampled high: state = IDLE, FIFO empty, pointers and count = 0, retry count = 0.
REQ-031 During and immediately after reset: wen = 0, w_data = 0, in_rdy = 1 (deasserted only while reset is high), busy = 0, err = 0.
REQ-032 An in-flight vector at reset is discarded; a wr_ack arriving after reset is ignored per REQ-024.

Structure
REQ-033 Shared package cgra_pkg holds the width and num_inputs defaults and the vec_tx state enum (IDLE, SEND, WAIT).
REQ-034 The FIFO is sub-module vec_fifo (push/pop/full/empty/head, registered count); FSM and retry logic stay in vec_tx.
REQ-035 All outputs are driven from registers or the registered FIFO head; there is no combinational path from wr_ack to wen.

Verification
REQ-036 Single vector {1,2,3,4} pushed into an idle block, ack the cycle after wen -> wen high exactly one cycle at N+2, w_data = {1,2,3,4}, busy low by N+4.
REQ-037 Three back-to-back pushes with fifo_depth = 2 -> in_rdy low after the second push; all three vectors are delivered in order with no duplicates.
REQ-038 No ack for the first 2 attempts, then ack -> wen pulses 3 times with identical w_data, one pop, err stays 0.
REQ-039 Never ack with max_retries = 7 -> exactly 7 wen pulses, head dropped, err = 1 and sticky, next vector sent afterwards.
REQ-040 Reset asserted during WAIT with 2 entries queued -> next cycle wen = 0, busy = 0, in_rdy = 1, err = 0; a late wr_ack causes no pop.
REQ-041 Stray wr_ack in IDLE and in SEND -> no pop, no state change, FIFO contents intact.
